// File: rtl/eth_gt_link_ctrl.sv
// GT bring-up sequencer and per-lane RX link recovery for one quad of the 10G Ethernet subsystem.
// A global FSM drives gt_reset_all/tx_ready; per-lane FSMs supervise block lock once TX is up.
module eth_gt_link_ctrl #(
    parameter int unsigned NUM_LANES     = 4,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned RESET_CYCLES  = 1024,
    parameter int unsigned TX_TIMEOUT    = 65536,
    parameter int unsigned LOCK_TIMEOUT  = 131072,
    parameter int unsigned RX_RST_CYCLES = 16,
    parameter int unsigned RETRY_WIDTH   = 8
) (
    input  logic                             clk_125mhz_int,
    input  logic                             gt_tx_reset,
    input  logic                             clock_ok,
    input  logic [NUM_LANES-1:0]             gt_powergood,
    input  logic [NUM_LANES-1:0]             tx_reset_done,
    input  logic [NUM_LANES-1:0]             rx_reset_done,
    input  logic [NUM_LANES-1:0]             rx_block_lock,
    output logic                             gt_reset_all,
    output logic [NUM_LANES-1:0]             gt_rx_datapath_reset,
    output logic                             tx_ready,
    output logic [NUM_LANES-1:0]             link_up,
    output logic [NUM_LANES*RETRY_WIDTH-1:0] rx_retry_count,
    output logic [RETRY_WIDTH-1:0]           tx_retry_count,
    output logic [1:0]                       ctrl_state
);

    localparam int unsigned GCntMax = (RESET_CYCLES > TX_TIMEOUT) ? RESET_CYCLES : TX_TIMEOUT;
    localparam int unsigned LCntMax = (LOCK_TIMEOUT > RX_RST_CYCLES) ? LOCK_TIMEOUT : RX_RST_CYCLES;
    localparam int unsigned GCW     = $clog2(GCntMax) + 1;
    localparam int unsigned LCW     = $clog2(LCntMax) + 1;
    localparam int unsigned IW      = 1 + 4 * NUM_LANES;

    localparam logic [GCW-1:0] ResetLast = GCW'(RESET_CYCLES - 1);
    localparam logic [GCW-1:0] TxLast    = GCW'(TX_TIMEOUT - 1);
    localparam logic [LCW-1:0] LockLast  = LCW'(LOCK_TIMEOUT - 1);
    localparam logic [LCW-1:0] RxRstLast = LCW'(RX_RST_CYCLES - 1);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StHold   = 2'd1;
    localparam logic [1:0] StWaitTx = 2'd2;
    localparam logic [1:0] StRun    = 2'd3;

    localparam logic [1:0] LnWaitLock = 2'd0;
    localparam logic [1:0] LnRxRst    = 2'd1;
    localparam logic [1:0] LnUp       = 2'd2;

    logic [SYNC_STAGES-1:0] rst_sync_q;
    logic                   rst;

    logic [IW-1:0]          in_async;
    logic [IW-1:0]          in_sync_q [SYNC_STAGES];
    logic                   s_clock_ok;
    logic [NUM_LANES-1:0]   s_gt_powergood;
    logic [NUM_LANES-1:0]   s_tx_reset_done;
    logic [NUM_LANES-1:0]   s_rx_reset_done;
    logic [NUM_LANES-1:0]   s_rx_block_lock;

    logic [1:0]             state_q, state_d;
    logic [GCW-1:0]         cnt_q, cnt_d;
    logic [RETRY_WIDTH-1:0] tx_retry_q, tx_retry_d;
    logic                   fault;
    logic                   lane_en;

    logic [1:0]             lane_state_q [NUM_LANES];
    logic [1:0]             lane_state_d [NUM_LANES];
    logic [LCW-1:0]         lane_cnt_q   [NUM_LANES];
    logic [LCW-1:0]         lane_cnt_d   [NUM_LANES];
    logic [RETRY_WIDTH-1:0] rx_retry_q   [NUM_LANES];
    logic [RETRY_WIDTH-1:0] rx_retry_d   [NUM_LANES];

    logic                   gt_reset_all_q;
    logic                   tx_ready_q;
    logic [NUM_LANES-1:0]   link_up_q;
    logic [NUM_LANES-1:0]   rx_dp_rst_q;

    // Asynchronous assertion, synchronised release.
    always_ff @(posedge clk_125mhz_int or posedge gt_tx_reset) begin
        if (gt_tx_reset) begin
            rst_sync_q <= '1;
        end else begin
            rst_sync_q <= {rst_sync_q[SYNC_STAGES-2:0], 1'b0};
        end
    end

    assign rst = rst_sync_q[SYNC_STAGES-1];

    assign in_async = {clock_ok, gt_powergood, tx_reset_done, rx_reset_done, rx_block_lock};

    always_ff @(posedge clk_125mhz_int or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                in_sync_q[i] <= '0;
            end
        end else begin
            in_sync_q[0] <= in_async;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                in_sync_q[i] <= in_sync_q[i-1];
            end
        end
    end

    assign {s_clock_ok, s_gt_powergood, s_tx_reset_done, s_rx_reset_done, s_rx_block_lock} =
        in_sync_q[SYNC_STAGES-1];

    assign fault = !s_clock_ok || !(&s_gt_powergood);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tx_retry_d = tx_retry_q;
        if (fault) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    state_d = StHold;
                    cnt_d   = '0;
                end
                StHold: begin
                    if (cnt_q == ResetLast) begin
                        state_d = StWaitTx;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StWaitTx: begin
                    // Completion wins over a timeout landing in the same cycle.
                    if (&s_tx_reset_done) begin
                        state_d = StRun;
                        cnt_d   = '0;
                    end else if (cnt_q == TxLast) begin
                        state_d = StHold;
                        cnt_d   = '0;
                        if (tx_retry_q != '1) begin
                            tx_retry_d = tx_retry_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    cnt_d = '0;
                end
            endcase
        end
    end

    // Lanes run only while RUN is held; leaving RUN parks them in WAIT_LOCK the same cycle.
    assign lane_en = (state_q == StRun) && (state_d == StRun);

    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            lane_state_d[i] = lane_state_q[i];
            lane_cnt_d[i]   = lane_cnt_q[i];
            rx_retry_d[i]   = rx_retry_q[i];
            if (!lane_en) begin
                lane_state_d[i] = LnWaitLock;
                lane_cnt_d[i]   = '0;
            end else begin
                case (lane_state_q[i])
                    LnWaitLock: begin
                        if (s_rx_block_lock[i]) begin
                            lane_state_d[i] = LnUp;
                            lane_cnt_d[i]   = '0;
                        end else if (s_rx_reset_done[i]) begin
                            if (lane_cnt_q[i] == LockLast) begin
                                lane_state_d[i] = LnRxRst;
                                lane_cnt_d[i]   = '0;
                                if (rx_retry_q[i] != '1) begin
                                    rx_retry_d[i] = rx_retry_q[i] + 1'b1;
                                end
                            end else begin
                                lane_cnt_d[i] = lane_cnt_q[i] + 1'b1;
                            end
                        end
                    end
                    LnRxRst: begin
                        if (lane_cnt_q[i] == RxRstLast) begin
                            lane_state_d[i] = LnWaitLock;
                            lane_cnt_d[i]   = '0;
                        end else begin
                            lane_cnt_d[i] = lane_cnt_q[i] + 1'b1;
                        end
                    end
                    LnUp: begin
                        if (!s_rx_block_lock[i]) begin
                            lane_state_d[i] = LnWaitLock;
                            lane_cnt_d[i]   = '0;
                        end
                    end
                    default: begin
                        lane_state_d[i] = LnWaitLock;
                        lane_cnt_d[i]   = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk_125mhz_int or posedge rst) begin
        if (rst) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            tx_retry_q     <= '0;
            gt_reset_all_q <= 1'b1;
            tx_ready_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            tx_retry_q     <= tx_retry_d;
            gt_reset_all_q <= (state_d == StIdle) || (state_d == StHold);
            tx_ready_q     <= (state_d == StRun);
        end
    end

    always_ff @(posedge clk_125mhz_int or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                lane_state_q[i] <= LnWaitLock;
                lane_cnt_q[i]   <= '0;
                rx_retry_q[i]   <= '0;
            end
            link_up_q   <= '0;
            rx_dp_rst_q <= '0;
        end else begin
            for (int i = 0; i < NUM_LANES; i++) begin
                lane_state_q[i] <= lane_state_d[i];
                lane_cnt_q[i]   <= lane_cnt_d[i];
                rx_retry_q[i]   <= rx_retry_d[i];
                link_up_q[i]    <= (lane_state_d[i] == LnUp);
                rx_dp_rst_q[i]  <= (lane_state_d[i] == LnRxRst);
            end
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_retry
        assign rx_retry_count[g*RETRY_WIDTH +: RETRY_WIDTH] = rx_retry_q[g];
    end

    assign gt_reset_all         = gt_reset_all_q;
    assign gt_rx_datapath_reset = rx_dp_rst_q;
    assign tx_ready             = tx_ready_q;
    assign link_up              = link_up_q;
    assign tx_retry_count       = tx_retry_q;
    assign ctrl_state           = state_q;

endmodule

// File: tb/tb_eth_gt_link_ctrl.sv
// Scenario bench for eth_gt_link_ctrl: bring-up, lock loss, lane recovery, faults, TX retries.
// Expected values are queued when stimulus is applied and compared when the DUT responds.
module tb_eth_gt_link_ctrl;

    typedef logic [51:0] obs_t;

    localparam obs_t RESET_OBS = {1'b1, 51'd0};

    logic        clk_125mhz_int = 1'b0;
    logic        gt_tx_reset;
    logic        clock_ok;
    logic [3:0]  gt_powergood;
    logic [3:0]  tx_reset_done;
    logic [3:0]  rx_reset_done;
    logic [3:0]  rx_block_lock;
    logic        gt_reset_all;
    logic [3:0]  gt_rx_datapath_reset;
    logic        tx_ready;
    logic [3:0]  link_up;
    logic [31:0] rx_retry_count;
    logic [7:0]  tx_retry_count;
    logic [1:0]  ctrl_state;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          exp_q[$];
    logic [3:0]  exp_lu_q[$];
    logic [31:0] exp_ret_q[$];
    obs_t        exp_obs_q[$];
    logic [31:0] exp_rx_retry = '0;
    obs_t        obs;

    always #4 clk_125mhz_int = ~clk_125mhz_int;

    assign obs = {gt_reset_all, gt_rx_datapath_reset, tx_ready, link_up, ctrl_state,
                  tx_retry_count, rx_retry_count};

    eth_gt_link_ctrl #(
        .NUM_LANES     (4),
        .SYNC_STAGES   (2),
        .RESET_CYCLES  (16),
        .TX_TIMEOUT    (64),
        .LOCK_TIMEOUT  (100),
        .RX_RST_CYCLES (8),
        .RETRY_WIDTH   (8)
    ) dut (
        .clk_125mhz_int       (clk_125mhz_int),
        .gt_tx_reset          (gt_tx_reset),
        .clock_ok             (clock_ok),
        .gt_powergood         (gt_powergood),
        .tx_reset_done        (tx_reset_done),
        .rx_reset_done        (rx_reset_done),
        .rx_block_lock        (rx_block_lock),
        .gt_reset_all         (gt_reset_all),
        .gt_rx_datapath_reset (gt_rx_datapath_reset),
        .tx_ready             (tx_ready),
        .link_up              (link_up),
        .rx_retry_count       (rx_retry_count),
        .tx_retry_count       (tx_retry_count),
        .ctrl_state           (ctrl_state)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_125mhz_int);
            #1;
        end
    endtask

    task automatic test_reset();
        obs_t e;
        gt_tx_reset   = 1'b1;
        clock_ok      = 1'b0;
        gt_powergood  = '0;
        tx_reset_done = '0;
        rx_reset_done = '0;
        rx_block_lock = '0;
        exp_obs_q.push_back(RESET_OBS);
        step(4);
        e = exp_obs_q.pop_front();
        n_checks++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want %h", obs, e);
        end
        // Healthy inputs must not move anything while reset is held.
        clock_ok      = 1'b1;
        gt_powergood  = 4'hF;
        rx_reset_done = 4'hF;
        rx_block_lock = 4'hF;
        exp_obs_q.push_back(RESET_OBS);
        step(6);
        e = exp_obs_q.pop_front();
        n_checks++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL reset_held_inputs_live: got %h want %h", obs, e);
        end
    endtask

    task automatic test_bringup();
        int b;
        int hold;
        int bad;
        int lat;
        int e;
        gt_tx_reset = 1'b0;
        exp_q.push_back(16);
        b = 0;
        while (ctrl_state !== 2'd1 && b < 20) begin
            step(1);
            b++;
        end
        n_checks++;
        if (ctrl_state !== 2'd1) begin
            n_fail++;
            $display("FAIL bringup_hold_entry: got state %0d want 1", ctrl_state);
        end
        hold = 0;
        bad  = 0;
        while (ctrl_state === 2'd1 && hold < 100) begin
            if (gt_reset_all !== 1'b1) bad++;
            hold++;
            step(1);
        end
        e = exp_q.pop_front();
        n_checks++;
        if (hold != e || bad != 0) begin
            n_fail++;
            $display("FAIL bringup_hold_len: got %0d cycles (%0d low) want %0d", hold, bad, e);
        end
        n_checks++;
        if (ctrl_state !== 2'd2 || gt_reset_all !== 1'b0) begin
            n_fail++;
            $display("FAIL bringup_wait_tx: got state %0d rst_all %b want 2/0",
                     ctrl_state, gt_reset_all);
        end
        step(10);
        tx_reset_done = 4'hF;
        exp_q.push_back(3);
        lat = 0;
        while (tx_ready !== 1'b1 && lat < 10) begin
            step(1);
            lat++;
        end
        e = exp_q.pop_front();
        n_checks++;
        if (lat != e || ctrl_state !== 2'd3) begin
            n_fail++;
            $display("FAIL bringup_tx_ready: got latency %0d state %0d want %0d/3",
                     lat, ctrl_state, e);
        end
        exp_lu_q.push_back(4'hF);
        step(1);
        n_checks++;
        if (link_up !== exp_lu_q[0] || gt_rx_datapath_reset !== 4'h0) begin
            n_fail++;
            $display("FAIL bringup_link_up: got %b/%b want %b/0000",
                     link_up, gt_rx_datapath_reset, exp_lu_q[0]);
        end
        void'(exp_lu_q.pop_front());
    endtask

    task automatic test_lock_loss();
        logic [3:0] e;
        rx_block_lock[0] = 1'b0;
        exp_lu_q.push_back(4'hF);
        exp_lu_q.push_back(4'hE);
        exp_lu_q.push_back(4'hF);
        step(1);
        rx_block_lock[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(1);
            e = exp_lu_q.pop_front();
            n_checks++;
            if (link_up !== e) begin
                n_fail++;
                $display("FAIL lock_loss_link_up_t%0d: got %b want %b", k + 2, link_up, e);
            end
        end
        n_checks++;
        if (rx_retry_count !== exp_rx_retry) begin
            n_fail++;
            $display("FAIL lock_loss_no_retry: got %h want %h", rx_retry_count, exp_rx_retry);
        end
    endtask

    task automatic test_lane_recovery();
        int gap;
        int width;
        int viol;
        int e;
        logic [31:0] er;
        rx_block_lock = 4'b1011;
        for (int k = 1; k <= 4; k++) begin
            exp_rx_retry[23:16] = exp_rx_retry[23:16] + 8'd1;
            exp_q.push_back(100);
            exp_ret_q.push_back(exp_rx_retry);
            exp_q.push_back(8);
        end
        step(3);
        n_checks++;
        if (link_up !== 4'b1011) begin
            n_fail++;
            $display("FAIL recovery_link_drop: got %b want 1011", link_up);
        end
        viol = 0;
        for (int k = 1; k <= 4; k++) begin
            gap = 0;
            while (gt_rx_datapath_reset[2] !== 1'b1 && gap < 200) begin
                if (link_up !== 4'b1011 || gt_rx_datapath_reset !== 4'b0000) viol++;
                step(1);
                gap++;
            end
            e = exp_q.pop_front();
            n_checks++;
            if (gap != e) begin
                n_fail++;
                $display("FAIL recovery_gap_%0d: got %0d want %0d", k, gap, e);
            end
            er = exp_ret_q.pop_front();
            n_checks++;
            if (rx_retry_count !== er) begin
                n_fail++;
                $display("FAIL recovery_retry_%0d: got %h want %h", k, rx_retry_count, er);
            end
            width = 0;
            while (gt_rx_datapath_reset[2] === 1'b1 && width < 50) begin
                if (link_up !== 4'b1011 || gt_rx_datapath_reset !== 4'b0100) viol++;
                width++;
                step(1);
            end
            e = exp_q.pop_front();
            n_checks++;
            if (width != e) begin
                n_fail++;
                $display("FAIL recovery_width_%0d: got %0d want %0d", k, width, e);
            end
        end
        n_checks++;
        if (viol != 0) begin
            n_fail++;
            $display("FAIL recovery_other_lanes: got %0d bad cycles want 0", viol);
        end
        rx_block_lock = 4'hF;
        exp_lu_q.push_back(4'hF);
        step(3);
        n_checks++;
        if (link_up !== exp_lu_q[0] || rx_retry_count !== exp_rx_retry) begin
            n_fail++;
            $display("FAIL recovery_relock: got %b/%h want %b/%h",
                     link_up, rx_retry_count, exp_lu_q[0], exp_rx_retry);
        end
        void'(exp_lu_q.pop_front());
    endtask

    task automatic test_mid_fault();
        int b;
        obs_t e;
        rx_block_lock = 4'b1101;
        exp_rx_retry[15:8] = exp_rx_retry[15:8] + 8'd1;
        exp_ret_q.push_back(exp_rx_retry);
        b = 0;
        while (gt_rx_datapath_reset[1] !== 1'b1 && b < 150) begin
            step(1);
            b++;
        end
        n_checks++;
        if (gt_rx_datapath_reset[1] !== 1'b1 || rx_retry_count !== exp_ret_q[0]) begin
            n_fail++;
            $display("FAIL fault_lane1_rx_rst: got %b/%h want 1/%h",
                     gt_rx_datapath_reset[1], rx_retry_count, exp_ret_q[0]);
        end
        void'(exp_ret_q.pop_front());
        step(2);
        clock_ok = 1'b0;
        exp_obs_q.push_back({1'b1, 4'h0, 1'b0, 4'h0, 2'd0, 8'd0, exp_rx_retry});
        step(2);
        n_checks++;
        if (ctrl_state !== 2'd3 || gt_rx_datapath_reset !== 4'b0010) begin
            n_fail++;
            $display("FAIL fault_not_early: got state %0d dp_rst %b want 3/0010",
                     ctrl_state, gt_rx_datapath_reset);
        end
        step(1);
        e = exp_obs_q.pop_front();
        n_checks++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL fault_to_idle: got %h want %h", obs, e);
        end
        // Mid-cycle assertion: no clock edge until the check below.
        #2;
        gt_tx_reset = 1'b1;
        exp_obs_q.push_back(RESET_OBS);
        #1;
        e = exp_obs_q.pop_front();
        n_checks++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL async_reset: got %h want %h", obs, e);
        end
        exp_rx_retry = '0;
    endtask

    task automatic test_tx_timeout();
        int b;
        int w;
        int h;
        int e;
        obs_t eo;
        step(2);
        clock_ok      = 1'b1;
        gt_powergood  = 4'hF;
        tx_reset_done = 4'h7;
        for (int i = 1; i <= 300; i++) exp_q.push_back(i < 255 ? i : 255);
        gt_tx_reset = 1'b0;
        b = 0;
        while (ctrl_state !== 2'd2 && b < 40) begin
            step(1);
            b++;
        end
        n_checks++;
        if (ctrl_state !== 2'd2) begin
            n_fail++;
            $display("FAIL tx_wait_entry: got state %0d want 2", ctrl_state);
        end
        for (int i = 1; i <= 300; i++) begin
            w = 0;
            while (ctrl_state === 2'd2 && w < 200) begin
                step(1);
                w++;
            end
            e = exp_q.pop_front();
            n_checks++;
            if (w != 64 || gt_reset_all !== 1'b1 || int'(tx_retry_count) != e) begin
                n_fail++;
                $display("FAIL tx_timeout_%0d: got wait %0d rst_all %b retry %0d want 64/1/%0d",
                         i, w, gt_reset_all, tx_retry_count, e);
            end
            h = 0;
            while (ctrl_state === 2'd1 && gt_reset_all === 1'b1 && h < 100) begin
                step(1);
                h++;
            end
            n_checks++;
            if (h != 16 || ctrl_state !== 2'd2) begin
                n_fail++;
                $display("FAIL tx_rehold_%0d: got %0d cycles state %0d want 16/2",
                         i, h, ctrl_state);
            end
        end
        gt_powergood = 4'hE;
        exp_obs_q.push_back({1'b1, 4'h0, 1'b0, 4'h0, 2'd0, 8'hFF, 32'h0});
        step(3);
        eo = exp_obs_q.pop_front();
        n_checks++;
        if (obs !== eo) begin
            n_fail++;
            $display("FAIL powergood_drop: got %h want %h", obs, eo);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_bringup();
        test_lock_loss();
        test_lane_recovery();
        test_mid_fault();
        test_tx_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
